padded_window_fetch: RTL and testbench
======================================

PADDED_WINDOW_FETCH -- requirements
Module: padded_window_fetch

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 16, giving the width of image dimensions and output-position coordinates.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the pixel width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, giving the memory address width.
REQ-004 SHALL have parameter KERNEL_SIZE, default 3, giving the square window edge (≥1).
REQ-005 SHALL have parameter STRIDE, default 1, giving the convolution stride (≥1).
REQ-006 SHALL have parameter PAD, default 1, giving the zero-padding width on each side (≥0, <KERNEL_SIZE).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit: begin a window fetch; sampled only in IDLE.
REQ-010 SHALL have ports out_x and out_y, input, COORD_WIDTH bits unsigned: output-pixel position, captured on accepted start.
REQ-011 SHALL have ports img_width and img_height, input, COORD_WIDTH bits unsigned: image size, captured on accepted start.
REQ-012 SHALL have port mem_rd_en, output, 1 bit: memory read strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_WIDTH bits: read address.
REQ-014 SHALL have port mem_rd_data, input, DATA_WIDTH bits: read data, valid exactly one cycle after mem_rd_en.
REQ-015 SHALL have ports pix_valid (output, 1), pix_ready (input, 1), pix_data (output, DATA_WIDTH) and pix_last (output, 1): tap-stream handshake.
REQ-016 SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), a one-cycle pulse.

Function
REQ-017 SHALL implement the states IDLE, FETCH, CAPT, OUT and DONE.
REQ-018 IDLE: start=1 SHALL capture the inputs, set origin_x = out_x*STRIDE - PAD and origin_y = out_y*STRIDE - PAD, clear kx and ky, and go to FETCH.
REQ-019 All coordinate arithmetic SHALL be signed at COORD_WIDTH+2 bits, with no overflow for any legal input.
REQ-020 Tap coordinates SHALL be x = origin_x+kx and y = origin_y+ky; the tap is in-bounds iff 0≤x<img_width and 0≤y<img_height.
REQ-021 FETCH, in-bounds tap: mem_rd_en=1 and mem_addr = y*img_width + x, truncated to ADDR_WIDTH; FETCH, out-of-bounds tap: mem_rd_en=0 and mem_addr holds its previous value. FETCH SHALL go to CAPT after one cycle.
REQ-022 CAPT SHALL register mem_rd_data into pix_data for an in-bounds tap, or zero for an out-of-bounds tap, then go to OUT.
REQ-023 OUT SHALL assert pix_valid=1 and hold pix_data and pix_last stable until pix_ready=1.
REQ-024 pix_last SHALL be 1 only for tap kx=ky=KERNEL_SIZE-1.
REQ-025 Taps SHALL be visited row-major: kx increments first, wraps to 0 at KERNEL_SIZE-1 and increments ky.
REQ-026 On the OUT handshake SHALL go to FETCH with the next tap, or to DONE if it was the last tap.
REQ-027 DONE SHALL assert done=1 for one cycle, then go to IDLE; with the defaults, 3 cycles per tap → 27 cycles from start to done with pix_ready held at 1.
REQ-028 start SHALL be ignored outside IDLE; captured inputs SHALL NOT change mid-window.
REQ-029 mem_rd_en SHALL be asserted at most once per tap and never outside FETCH.
REQ-030 img_width=0 or img_height=0 SHALL make every tap out-of-bounds: nine zeros, no reads.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and set mem_rd_en=0, mem_addr=0, pix_valid=0, pix_data=0, pix_last=0, busy=0, done=0 and kx=ky=0, including mid-window; no partial window resumes after reset.

Verification (K=3, STRIDE=1, PAD=1, img 4x4, pixel value = address)
REQ-032 Corner: start out=(0,0) → reads at addr 0,1,4,5 only; pix_data stream 0,0,0,0,0,1,0,4,5; pix_last on the 9th tap; done one cycle later.
REQ-033 Interior: out=(1,1) → nine reads at addr 0,1,2,4,5,6,8,9,10; pix_data equals those addresses in order.
REQ-034 Far corner: out=(3,3) → reads at addr 10,11,14,15; stream 10,11,0,14,15,0,0,0,0.
REQ-035 Backpressure: pix_ready low 5 cycles on tap 4 → pix_valid and pix_data held, no extra mem_rd_en, stream unchanged.
REQ-036 Abuse: start pulsed while busy → ignored; rst_n low during tap 5 → all outputs 0 at once; a new start after reset runs a full clean window.

Source files
------------

// File: rtl/padded_window_fetch.sv
// Fetches one KERNEL_SIZE x KERNEL_SIZE input window for a convolution output
// pixel, substituting zeros for taps that fall in the padding border.
module padded_window_fetch #(
  parameter int COORD_WIDTH = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PAD         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] out_x,
  input  logic [COORD_WIDTH-1:0] out_y,
  input  logic [COORD_WIDTH-1:0] img_width,
  input  logic [COORD_WIDTH-1:0] img_height,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [DATA_WIDTH-1:0]  pix_data,
  output logic                   pix_last,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             state_dbg
);

  // Tap stream handshake: a tap transfers on a rising edge where pix_valid and
  // pix_ready are both high; while pix_valid is high and pix_ready is low,
  // pix_data and pix_last hold, and pix_valid never drops before the transfer.

  localparam int SW = COORD_WIDTH + 2;
  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic signed [SW-1:0] STRIDE_S = SW'(STRIDE);
  localparam logic signed [SW-1:0] PAD_S    = SW'(PAD);
  localparam logic [KW-1:0]        KMAX     = KW'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic signed [SW-1:0]    org_x_q, org_x_d;
  logic signed [SW-1:0]    org_y_q, org_y_d;
  logic [COORD_WIDTH-1:0]  w_q, w_d;
  logic [COORD_WIDTH-1:0]  h_q, h_d;
  logic [KW-1:0]           kx_q, kx_d;
  logic [KW-1:0]           ky_q, ky_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   pix_data_q, pix_data_d;
  logic                    pix_last_q, pix_last_d;

  logic signed [SW-1:0]    tap_x, tap_y;
  logic                    tap_inb;
  logic [2*SW-1:0]         lin_addr;

  // Coordinates of the current tap; bounds checks are signed so the padding
  // border (negative coordinates) is rejected naturally.
  always_comb begin
    tap_x    = org_x_q + $signed(SW'(kx_q));
    tap_y    = org_y_q + $signed(SW'(ky_q));
    tap_inb  = !tap_x[SW-1] && !tap_y[SW-1] &&
               (tap_x < $signed({2'b00, w_q})) &&
               (tap_y < $signed({2'b00, h_q}));
    lin_addr = {{SW{1'b0}}, tap_y} * {{(SW+2){1'b0}}, w_q} + {{SW{1'b0}}, tap_x};
  end

  always_comb begin
    state_d    = state_q;
    org_x_d    = org_x_q;
    org_y_d    = org_y_q;
    w_d        = w_q;
    h_d        = h_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    addr_d     = addr_q;
    pix_data_d = pix_data_q;
    pix_last_d = pix_last_q;
    mem_rd_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          org_x_d = $signed({2'b00, out_x}) * STRIDE_S - PAD_S;
          org_y_d = $signed({2'b00, out_y}) * STRIDE_S - PAD_S;
          w_d     = img_width;
          h_d     = img_height;
          kx_d    = '0;
          ky_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (tap_inb) begin
          mem_rd_en = 1'b1;
          addr_d    = lin_addr[ADDR_WIDTH-1:0];
        end
        state_d = S_CAPT;
      end
      S_CAPT: begin
        pix_data_d = tap_inb ? mem_rd_data : '0;
        pix_last_d = (kx_q == KMAX) && (ky_q == KMAX);
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (pix_ready) begin
          if (pix_last_q) begin
            state_d = S_DONE;
          end else begin
            if (kx_q == KMAX) begin
              kx_d = '0;
              ky_d = ky_q + 1'b1;
            end else begin
              kx_d = kx_q + 1'b1;
            end
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      org_x_q    <= '0;
      org_y_q    <= '0;
      w_q        <= '0;
      h_q        <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      addr_q     <= '0;
      pix_data_q <= '0;
      pix_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      org_x_q    <= org_x_d;
      org_y_q    <= org_y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      addr_q     <= addr_d;
      pix_data_q <= pix_data_d;
      pix_last_q <= pix_last_d;
    end
  end

  // The address presented in FETCH is the one being registered, so an
  // out-of-bounds tap leaves the previous address on the bus.
  assign mem_addr  = addr_d;
  assign pix_valid = (state_q == S_OUT);
  assign pix_data  = pix_data_q;
  assign pix_last  = pix_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_padded_window_fetch.sv
// Randomized and directed bench for padded_window_fetch against a behavioural
// window model (tap list computed directly from origin/bounds arithmetic).
module tb_padded_window_fetch;

  localparam int K      = 3;
  localparam int STRIDE = 1;
  localparam int PAD    = 1;
  localparam int MEMSZ  = 1024;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] out_x, out_y, img_width, img_height;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        pix_valid, pix_ready, pix_last, busy, done;
  logic [7:0]  pix_data;
  logic [2:0]  state_dbg;

  padded_window_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .out_x       (out_x),
    .out_y       (out_y),
    .img_width   (img_width),
    .img_height  (img_height),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:MEMSZ-1];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr % MEMSZ];
    else           mem_rd_data <= 8'($urandom);
  end

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];
  bit          mon_en = 0;
  int          taps_seen = 0;
  bit          hold_pending = 0;
  logic [8:0]  held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected window straight from the origin/bounds rules.
  task automatic load_model(input int x, input int y, input int w, input int h);
    int ox, oy, tx, ty, a;
    exp_q.delete();
    exp_addr_q.delete();
    ox = x * STRIDE - PAD;
    oy = y * STRIDE - PAD;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        tx = ox + kx;
        ty = oy + ky;
        if (tx >= 0 && tx < w && ty >= 0 && ty < h) begin
          a = (ty * w + tx) & 32'hFFFF;
          exp_addr_q.push_back(16'(a));
          exp_q.push_back({(kx == K-1 && ky == K-1), mem[a % MEMSZ]});
        end else begin
          exp_q.push_back({(kx == K-1 && ky == K-1), 8'h00});
        end
      end
    end
  endtask

  // Monitor: samples between the driver's negedge updates and the next posedge.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) check_eq("unexpected_read", 1, 0);
        else check_eq("rd_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (pix_valid) begin
        if (hold_pending) check_eq("hold_tap", {pix_last, pix_data}, held);
        if (pix_ready) begin
          if (exp_q.size() == 0) check_eq("extra_tap", 1, 0);
          else check_eq("tap", {pix_last, pix_data}, exp_q.pop_front());
          taps_seen++;
          hold_pending = 0;
        end else begin
          held = {pix_last, pix_data};
          hold_pending = 1;
        end
      end else begin
        hold_pending = 0;
      end
    end
  end

  // mode 0: ready always high, 1: random ready, 2: stall 5 cycles on tap 4
  task automatic run_window(input int x, input int y, input int w, input int h,
                            input int mode, input bit abuse);
    int cnt, stall;
    load_model(x, y, w, h);
    taps_seen = 0;
    hold_pending = 0;
    @(negedge clk);
    out_x = 16'(x); out_y = 16'(y); img_width = 16'(w); img_height = 16'(h);
    start = 1'b1;
    pix_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    cnt = 0;
    stall = 0;
    while (1) begin
      @(posedge clk);
      @(negedge clk);
      start = (abuse && cnt == 10);
      out_x = 16'($urandom); out_y = 16'($urandom);
      img_width = 16'($urandom); img_height = 16'($urandom);
      if (done) break;
      cnt++;
      if (cnt > 600) begin
        check_eq("done_timeout", 1, 0);
        break;
      end
      if (mode == 1) pix_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && taps_seen == 3 && pix_valid && stall < 5) begin
        pix_ready = 1'b0;
        stall++;
      end else pix_ready = 1'b1;
    end
    start = 1'b0;
    if (mode == 0) check_eq("latency", cnt, 27);
    if (mode == 2) check_eq("latency_bp", cnt, 32);
    check_eq("busy_in_done", busy, 1);
    check_eq("taps_left", exp_q.size(), 0);
    check_eq("reads_left", exp_addr_q.size(), 0);
    check_eq("taps_seen", taps_seen, K * K);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("idle_after_done", busy, 0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rd_en"}, mem_rd_en, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_valid"}, pix_valid, 0);
    check_eq({tag, "_data"}, pix_data, 0);
    check_eq({tag, "_last"}, pix_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
    out_x = '0; out_y = '0; img_width = '0; img_height = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    mon_en = 1;

    run_window(0, 0, 4, 4, 0, 0);
    run_window(1, 1, 4, 4, 0, 0);
    run_window(3, 3, 4, 4, 0, 0);
    run_window(1, 1, 4, 4, 2, 0);
    run_window(2, 1, 4, 4, 0, 1);
    run_window(1, 1, 0, 4, 0, 0);
    run_window(1, 1, 4, 0, 0, 0);

    // reset in the middle of tap 5
    load_model(1, 1, 4, 4);
    taps_seen = 0;
    @(negedge clk);
    out_x = 16'd1; out_y = 16'd1; img_width = 16'd4; img_height = 16'd4;
    start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && taps_seen < 4; c++) @(negedge clk);
    check_eq("reach_tap5", taps_seen, 4);
    @(posedge clk);
    #3;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    exp_q.delete();
    exp_addr_q.delete();
    hold_pending = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_held_idle", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
    run_window(1, 1, 4, 4, 0, 0);

    run_window(65535, 2, 4, 4, 0, 0);
    run_window(299, 299, 300, 300, 0, 0);
    run_window(150, 250, 300, 300, 1, 0);

    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 40; t++) begin
      int w, h;
      w = $urandom_range(0, 20);
      h = $urandom_range(0, 20);
      run_window($urandom_range(0, w + 1), $urandom_range(0, h + 1), w, h,
                 $urandom_range(0, 1), $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
